// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM layer controllers: default dimensions,
// sequencer state encoding and the element-slice helper.
package lstm_pkg;

  localparam int DEF_M           = 256;
  localparam int DEF_N           = 512;
  localparam int DEF_DATA_WIDTH  = 24;
  localparam int DEF_FRACT_WIDTH = 13;
  localparam int DEF_MAX_T       = 64;
  localparam int DEF_CORE_LAT    = 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_CAPT = 3'd3,
    ST_EMIT = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // Element k of a packed vector starts at bit k*dw (use with +: dw).
  function automatic int elem_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/lstm_state_reg.sv
// Recurrent h/c state register pair with synchronous clear and load;
// shared by the controllers of every LSTM layer.
module lstm_state_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] h_in,
  input  logic [W-1:0] c_in,
  output logic [W-1:0] h_q,
  output logic [W-1:0] c_q
);

  // Clear wins over load so a new sequence always starts from zero state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q <= '0;
      c_q <= '0;
    end else if (clr) begin
      h_q <= '0;
      c_q <= '0;
    end else if (ld) begin
      h_q <= h_in;
      c_q <= c_in;
    end else begin
      h_q <= h_q;
      c_q <= c_q;
    end
  end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Sequencer around the single-timestep lstm core: feeds xt plus recurrent
// h/c state per step, captures the core result and streams h_t downstream.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int M           = DEF_M,
  parameter int N           = DEF_N,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
  parameter int MAX_T       = DEF_MAX_T,
  parameter int CORE_LAT    = DEF_CORE_LAT,
  parameter int LW          = $clog2(MAX_T + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LW-1:0]           seq_len,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic [N*DATA_WIDTH-1:0] x_data,
  output logic [N*DATA_WIDTH-1:0] core_xt,
  output logic [M*DATA_WIDTH-1:0] core_ht,
  output logic [M*DATA_WIDTH-1:0] core_ct,
  input  logic [M*DATA_WIDTH-1:0] core_h,
  input  logic [M*DATA_WIDTH-1:0] core_c,
  output logic                    h_valid,
  input  logic                    h_ready,
  output logic [M*DATA_WIDTH-1:0] h_data,
  output logic                    h_last,
  output logic [LW-1:0]           step_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int WW = (CORE_LAT < 1) ? 1 : $clog2(CORE_LAT + 1);

  if (CORE_LAT < 1) begin : g_bad_core_lat
    $error("lstm_seq_ctrl: CORE_LAT must be at least 1");
  end
  if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract_width
    $error("lstm_seq_ctrl: FRACT_WIDTH must be below DATA_WIDTH");
  end

  state_t        state_r;
  logic [LW-1:0] len_r;
  logic [WW-1:0] wait_r;
  logic [LW-1:0] len_clamp_s;
  logic          clr_s;
  logic          ld_s;

  assign len_clamp_s = (seq_len > LW'(MAX_T)) ? LW'(MAX_T) : seq_len;
  assign clr_s       = (state_r == ST_IDLE) && start;
  assign ld_s        = (state_r == ST_CAPT);

  lstm_state_reg #(
    .W(M * DATA_WIDTH)
  ) u_state_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr_s),
    .ld   (ld_s),
    .h_in (core_h),
    .c_in (core_c),
    .h_q  (core_ht),
    .c_q  (core_ct)
  );

  // Step sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      len_r    <= '0;
      wait_r   <= '0;
      x_ready  <= 1'b0;
      core_xt  <= '0;
      h_valid  <= 1'b0;
      h_data   <= '0;
      h_last   <= 1'b0;
      step_idx <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r    <= len_clamp_s;
            step_idx <= '0;
            busy     <= 1'b1;
            if (len_clamp_s == '0) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
              x_ready <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (x_valid && x_ready) begin
            core_xt <= x_data;
            wait_r  <= WW'(CORE_LAT);
            x_ready <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_r <= wait_r - WW'(1);
          if (wait_r == WW'(1)) begin
            state_r <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          h_data  <= core_h;
          h_valid <= 1'b1;
          h_last  <= (step_idx == (len_r - LW'(1)));
          state_r <= ST_EMIT;
        end
        ST_EMIT: begin
          if (h_ready) begin
            h_valid <= 1'b0;
            h_last  <= 1'b0;
            if (h_last) begin
              state_r <= ST_FIN;
              done    <= 1'b1;
            end else begin
              step_idx <= step_idx + LW'(1);
              x_ready  <= 1'b1;
              state_r  <= ST_LOAD;
            end
          end
        end
        ST_FIN: begin
          done     <= 1'b0;
          busy     <= 1'b0;
          step_idx <= '0;
          state_r  <= ST_IDLE;
        end
        default: begin
          x_ready <= 1'b0;
          h_valid <= 1'b0;
          h_last  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl with a pipelined stub core (h += x per element).
module tb_lstm_seq_ctrl;
  import lstm_pkg::*;

  localparam int M  = 2;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int CL = 2;
  localparam int MT = 8;
  localparam int LW = $clog2(MT + 1);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [LW-1:0]   seq_len = '0;
  logic            x_valid;
  logic            x_ready;
  logic [N*DW-1:0] x_data;
  logic [N*DW-1:0] core_xt;
  logic [M*DW-1:0] core_ht, core_ct, core_h, core_c;
  logic            h_valid;
  logic            h_ready = 1'b1;
  logic [M*DW-1:0] h_data;
  logic            h_last;
  logic [LW-1:0]   step_idx;
  logic            busy, done;

  lstm_seq_ctrl #(.M(M), .N(N), .DATA_WIDTH(DW), .FRACT_WIDTH(4), .MAX_T(MT), .CORE_LAT(CL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seq_len(seq_len),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .core_xt(core_xt), .core_ht(core_ht), .core_ct(core_ct),
    .core_h(core_h), .core_c(core_c),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_last(h_last),
    .step_idx(step_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stub core with a true CL-cycle pipeline: stale captures show up as wrong data.
  logic [M*DW-1:0] p1, p2;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      for (int k = 0; k < M; k++)
        p1[k*DW +: DW] <= core_xt[k*DW +: DW] + core_ht[k*DW +: DW];
      p2 <= p1;
    end
  end
  assign core_h = p2;
  assign core_c = p2;

  typedef struct packed { logic [M*DW-1:0] h; logic last; } exp_t;
  exp_t            exp_q[$];
  logic [N*DW-1:0] x_q[$];
  int              h_hs_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, x_hs_cnt = 0;
  int gap_cfg = 0, gap_cnt = 0;
  bit rand_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream driver: one queued xt per handshake, with an optional idle gap before each.
  initial begin
    bit hs;
    x_valid = 1'b0;
    x_data  = '0;
    forever begin
      @(negedge clk);
      hs = x_valid && x_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        if (x_q.size() != 0) void'(x_q.pop_front());
        x_valid = 1'b0;
        gap_cnt = gap_cfg;
        x_hs_cnt++;
      end
      if (!x_valid && x_q.size() != 0) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          x_valid = 1'b1;
          x_data  = x_q[0];
        end
      end
    end
  end

  // Output monitor: compares every h handshake against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (h_valid && h_ready) begin
        h_hs_q.push_back(cyc + 1);
        chk("h_expected_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("h_data", 32'(h_data), 32'(e.h));
          chk("h_last", 32'(h_last), 32'(e.last));
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) h_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Reference model: h starts at zero and accumulates x element-wise, mod 2^DW.
  task automatic run_seq(input int len_req, input int gap, input bit ones);
    int L;
    logic [M*DW-1:0] h;
    logic [N*DW-1:0] x;
    exp_t e;
    L = (len_req > MT) ? MT : len_req;
    h = '0;
    for (int t = 0; t < L; t++) begin
      for (int k = 0; k < N; k++)
        x[elem_lsb(k, DW) +: DW] = ones ? 8'd1 : 8'($urandom_range(0, 255));
      x_q.push_back(x);
      for (int k = 0; k < M; k++)
        h[elem_lsb(k, DW) +: DW] = h[elem_lsb(k, DW) +: DW] + x[elem_lsb(k, DW) +: DW];
      e.h = h;
      e.last = (t == L - 1);
      exp_q.push_back(e);
    end
    gap_cfg = gap;
    gap_cnt = gap;
    seq_len = LW'(len_req);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < bound) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    tick();
    chk({name, "_all_h_seen"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_all_x_used"}, 32'(x_q.size()), 32'd0);
  endtask

  initial begin
    int d0, b0, n, xb;
    logic [M*DW-1:0] hold_h;
    logic [N*DW-1:0] hold_x;

    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, n, xb;
    logic [M*DW-1:0] hold_h;
    logic [N*DW-1:0] hold_x;

    repeat (3) tick();
    chk("rst_x_ready", 32'(x_ready), 32'd0);
    chk("rst_h_valid", 32'(h_valid), 32'd0);
    chk("rst_h_last", 32'(h_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step_idx", 32'(step_idx), 32'd0);
    chk("rst_core_xt", 32'(core_xt), 32'd0);
    chk("rst_core_ht", 32'(core_ht), 32'd0);
    chk("rst_core_ct", 32'(core_ct), 32'd0);
    chk("rst_h_data", 32'(h_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full-rate run of three steps of ones.
    h_ready = 1'b1;
    h_hs_q.delete();
    d0 = done_cnt;
    run_seq(3, 0, 1'b1);
    wait_done("s2", 200);
    chk("s2_done_count", 32'(done_cnt - d0), 32'd1);
    chk("s2_h_count", 32'(h_hs_q.size()), 32'd3);
    if (h_hs_q.size() == 3) begin
      chk("s2_period_a", 32'(h_hs_q[1] - h_hs_q[0]), 32'(CL + 3));
      chk("s2_period_b", 32'(h_hs_q[2] - h_hs_q[1]), 32'(CL + 3));
      chk("s2_done_timing", 32'(done_cyc), 32'(h_hs_q[2]));
    end
    chk("s2_busy_after", 32'(busy), 32'd0);

    // Zero-length sequence.
    d0 = done_cnt;
    b0 = busy_cnt;
    seq_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s3_done_high", 32'(done), 32'd1);
    chk("s3_busy_high", 32'(busy), 32'd1);
    chk("s3_x_ready_a", 32'(x_ready), 32'd0);
    tick();
    chk("s3_done_low", 32'(done), 32'd0);
    chk("s3_busy_low", 32'(busy), 32'd0);
    repeat (4) begin
      tick();
      chk("s3_x_ready_b", 32'(x_ready), 32'd0);
    end
    chk("s3_busy_cycles", 32'(busy_cnt - b0), 32'd1);
    chk("s3_done_count", 32'(done_cnt - d0), 32'd1);

    // Backpressure on step 0.
    h_ready = 1'b0;
    run_seq(2, 0, 1'b0);
    n = 0;
    while (!h_valid && n < 50) begin
      tick();
      n++;
    end
    chk("s4_h_valid_rise", 32'(h_valid), 32'd1);
    hold_h = h_data;
    hold_x = core_xt;
    repeat (7) begin
      chk("s4_h_valid_hold", 32'(h_valid), 32'd1);
      chk("s4_h_data_hold", 32'(h_data), 32'(hold_h));
      chk("s4_core_xt_hold", 32'(core_xt), 32'(hold_x));
      chk("s4_x_ready_low", 32'(x_ready), 32'd0);
      chk("s4_step_idx", 32'(step_idx), 32'd0);
      tick();
    end
    h_ready = 1'b1;
    wait_done("s4", 200);

    // Gapped upstream, with a stray start while busy.
    d0 = done_cnt;
    run_seq(3, 4, 1'b1);
    repeat (3) tick();
    seq_len = LW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("s5", 300);
    repeat (10) tick();
    chk("s5_done_count", 32'(done_cnt - d0), 32'd1);
    chk("s5_busy_after", 32'(busy), 32'd0);

    // Over-long request clamps to MT steps.
    h_hs_q.delete();
    run_seq(MT + 5, 0, 1'b0);
    wait_done("s6", 600);
    chk("s6_h_count", 32'(h_hs_q.size()), 32'(MT));
    chk("s6_step_idx_wrap", 32'(step_idx), 32'd0);
    repeat (10) tick();
    chk("s6_busy_after", 32'(busy), 32'd0);

    // Reset in the wait phase of step 1.
    xb = x_hs_cnt;
    run_seq(3, 0, 1'b0);
    n = 0;
    while (x_hs_cnt < xb + 2 && n < 100) begin
      tick();
      n++;
    end
    chk("s1_reached_step1", 32'(x_hs_cnt - xb), 32'd2);
    exp_q.delete();
    x_q.delete();
    x_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_h_valid", 32'(h_valid), 32'd0);
    chk("s1_step_idx", 32'(step_idx), 32'd0);
    chk("s1_x_ready", 32'(x_ready), 32'd0);
    chk("s1_core_ht", 32'(core_ht), 32'd0);
    rst_n = 1'b1;
    repeat (12) tick();
    chk("s1_no_output", 32'(h_valid), 32'd0);
    run_seq(1, 0, 1'b0);
    wait_done("s1_fresh", 200);

    // Randomized sequences with gaps and backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_seq($urandom_range(1, MT + 2), $urandom_range(0, 3), 1'b0);
      wait_done("rnd", 1500);
    end
    rand_bp = 1'b0;
    h_ready = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lstm_seq_ctrl.md
Name: lstm_seq_ctrl

Overview:
Sequencer wrapped around the single-timestep `lstm` datapath. It runs one sequence of up to MAX_T timesteps. For each timestep it:
- accepts one xt vector from an upstream stream,
- presents xt and the recurrent h/c state to the core,
- waits the core's fixed latency,
- captures c_t/h_t into internal state registers,
- emits h_t downstream.

The recurrent state lives here, not in the testbench loop. Sits between the CNN feature buffer and the CTC/FC stage.

Parameters:
- M, 256, hidden size (elements in h_t, c_t)
- N, 512, input size (elements in xt)
- DATA_WIDTH, 24, signed fixed-point element width
- FRACT_WIDTH, 13, fractional bits (pass-through only; no arithmetic here)
- MAX_T, 64, maximum sequence length
- CORE_LAT, 1, cycles from core inputs stable to core outputs valid; must be >=1
- LW, $clog2(MAX_T+1), width of the length and step fields

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- seq_len  in  LW  timesteps to run; sampled with start; values >MAX_T are clamped to MAX_T
- x_valid  in  1  upstream xt valid
- x_ready  out  1  xt accepted when x_valid&&x_ready
- x_data  in  N*DATA_WIDTH  xt vector
- core_xt  out  N*DATA_WIDTH  registered xt held to the core
- core_ht  out  M*DATA_WIDTH  h state to core (htI)
- core_ct  out  M*DATA_WIDTH  c state to core (ctI)
- core_h  in  M*DATA_WIDTH  core h_t_out
- core_c  in  M*DATA_WIDTH  core c_t_out
- h_valid  out  1  h_t output valid
- h_ready  in  1  downstream ready
- h_data  out  M*DATA_WIDTH  h_t of current step
- h_last  out  1  high with h_valid on the final step
- step_idx  out  LW  index of the step in progress (0-based)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the sequence completes

Behaviour:
Reset (rst_n low at a clock edge):
- State = IDLE.
- All outputs 0: x_ready, h_valid, h_last, busy, done, step_idx, core_xt, core_ht, core_ct, h_data.
- Internal len and wait counters = 0.
- Reset mid-sequence aborts immediately. No partial output is emitted afterwards.

FSM states: IDLE, LOAD, WAIT, CAPT, EMIT, FIN.

IDLE:
- On start: latch the clamped seq_len; zero core_ht and core_ct (zero initial state); step_idx=0.
- If the latched length is 0, go to FIN. Otherwise go to LOAD.
- start outside IDLE is ignored.

LOAD:
- x_ready=1.
- On handshake: core_xt<=x_data, wait counter<=CORE_LAT, go to WAIT.
- x_ready drops in the cycle after the handshake. Exactly one xt is accepted per step.

WAIT:
- Decrement the wait counter each cycle.
- When the counter reaches 1, go to CAPT.
- core_xt, core_ht and core_ct stay stable throughout.

CAPT (one cycle):
- core_ht<=core_h, core_ct<=core_c, h_data<=core_h.
- h_valid<=1; h_last<=(step_idx==len-1). Go to EMIT.

EMIT:
- Hold h_valid, h_data and h_last until h_ready.
- On the handshake: h_valid<=0.
  - If h_last: go to FIN.
  - Else: step_idx+=1 and go to LOAD.
- The core inputs do not change while backpressured.

FIN (one cycle):
- done=1, then go to IDLE. busy is 0 from IDLE onward.
- The h/c state is retained until the next start.

Timing:
- Step latency from the xt handshake to h_valid rising = CORE_LAT+1 cycles.
- Minimum step period = CORE_LAT+3 cycles with x_valid and h_ready held high.

Data handling:
- No arithmetic; widths are exact and there is no truncation.
- Element k of any vector occupies bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].

Decomposition:
- Shared package `lstm_pkg` holds:
  - the FSM state encoding (localparam enum),
  - the default M, N, DATA_WIDTH, FRACT_WIDTH,
  - the vector-slice helper function.
- One natural sub-module: `lstm_state_reg`, the h/c state register pair with clear and load enables. It is reused by the second LSTM layer's controller.

Test Plan:
Bench setup: M=2, N=2, DATA_WIDTH=8, CORE_LAT=2. Stub core computes core_h = x[0]+h[0] per element and core_c = core_h.
1. Reset mid-WAIT at step 1 of a len=3 run:
   - busy=0, h_valid=0 and step_idx=0 the next cycle.
   - No further h output.
   - A fresh start with len=1 runs from zeroed state.
2. start, seq_len=3, x_data=1 every step, x_valid and h_ready tied high:
   - h_data elements = 1, 2, 3.
   - h_last only on the third output.
   - done pulses once, 1 cycle after the third handshake.
   - Step period 5 cycles.
3. seq_len=0:
   - x_ready never asserts.
   - done pulses on the second cycle after start.
   - busy high exactly 1 cycle.
4. h_ready held low 7 cycles at step 0:
   - h_valid and h_data stable for all 7 cycles.
   - x_ready stays 0.
   - Step 1 proceeds once h_ready rises.
5. x_valid gapped 4 cycles before each step:
   - Outputs are identical to scenario 2; only the timing shifts.
   - start pulses during busy are ignored.
6. seq_len=MAX_T+5 → exactly MAX_T outputs, h_last on the last one, step_idx wraps to 0 after FIN.
